stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Fetch/hazard controller that sequences the program counter and the IF/ID and ID/EX pipeline registers. It sits beside the PC and drives the PC's `pipline_stop`, `pipline_stop_jump` and `din` inputs. It detects load-use hazards and holds fetch while a branch or jump resolves. It then presents the redirect target in the cycle the PC expects it and flushes the wrong-path instruction.

## Interface
- `JUMP_TIMEOUT`, 15: maximum number of JUMP_WAIT cycles before `jump_err` is set.
- `CNT_W`, 16: width of the stall performance counters.
- `clk_sc`  in  1: clock. One clock domain only.
- `rst_sc`  in  1: reset, synchronous, active-high.
- `id_valid`  in  1: the ID stage holds a real instruction.
- `id_is_jump`  in  1: the ID instruction is a branch, jal or jalr.
- `id_rs1`, `id_rs2`  in  5 each: source register indices.
- `id_rs1_used`, `id_rs2_used`  in  1 each: the instruction reads that source.
- `ex_valid`  in  1: the EX stage holds a real instruction.
- `ex_mem_read`  in  1: the EX instruction is a load.
- `ex_rd`  in  5: destination register of the EX instruction.
- `ex_br_resolved`  in  1: single-cycle pulse; the control instruction in EX has resolved.
- `ex_br_taken`  in  1: the branch is taken; valid with `ex_br_resolved`.
- `ex_br_target`  in  32: taken target address.
- `ex_br_pc4`  in  32: fall-through address.
- `pipline_stop`  out  1: PC hold for a load-use stall.
- `pipline_stop_jump`  out  1: PC hold while a jump is unresolved.
- `npc`  out  32: redirect address, drives the PC's `din`.
- `stall_ifid`  out  1: IF/ID holds its contents.
- `flush_ifid`  out  1: IF/ID loads a bubble.
- `flush_idex`  out  1: ID/EX loads a bubble.
- `jump_err`  out  1: sticky flag, set when a jump wait times out.
- `load_stall_cnt`, `jump_stall_cnt`  out  CNT_W each: saturating stall-cycle counters.

## Operation
- States:
  - BOOT: entered on reset. Lasts 1 cycle, then goes to RUN.
  - RUN: normal flow.
  - JUMP_WAIT: fetch is held until the control instruction resolves.
  - REDIRECT: lasts 1 cycle, then goes to RUN.
- Load-use hazard, evaluated combinationally:
  - Condition: `id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))`.
- RUN outputs:
  - If a load-use hazard is present: `pipline_stop`=1, `stall_ifid`=1, `flush_idex`=1. State stays RUN. The hazard clears naturally once the load leaves EX.
  - Else if `id_valid & id_is_jump`: `pipline_stop_jump`=1, then go to JUMP_WAIT.
  - Load-use has priority over jump. A jalr that depends on a load stalls first and enters JUMP_WAIT on a later cycle.
- JUMP_WAIT outputs: `pipline_stop_jump`=1, `stall_ifid`=1, `flush_idex`=1.
  - On `ex_br_resolved`, capture `npc_q = ex_br_taken ? ex_br_target : ex_br_pc4`, then go to REDIRECT.
  - The wait counter increments each cycle. When it reaches `JUMP_TIMEOUT`, set `jump_err` and force REDIRECT with `npc_q = ex_br_pc4`.
- REDIRECT outputs: `pipline_stop_jump`=0, `npc`=`npc_q`, `flush_ifid`=1 to drop the wrong-path fetch. This cycle is the PC's first-after-jump cycle, so the PC loads `npc` at the following edge.
- BOOT outputs: `flush_ifid`=1, `flush_idex`=1, all stops 0. This matches the PC's forced-zero first cycle.
- `ex_br_resolved` outside JUMP_WAIT is ignored.
- `npc` holds `npc_q` in every state.
- Counters:
  - `load_stall_cnt` increments on each cycle with `pipline_stop`=1.
  - `jump_stall_cnt` increments on each cycle with `pipline_stop_jump`=1.
  - Both saturate at 2^CNT_W-1 and do not wrap.

## Timing
- Reset values: state BOOT, `npc_q`=0, counters 0, `jump_err`=0, wait counter 0.
- While `rst_sc` is high, outputs show the BOOT values. Reset during JUMP_WAIT or REDIRECT abandons the pending redirect.
- Stop, stall and flush outputs are combinational from the state and current inputs, so they take effect in the same cycle. `npc` comes from a register.
- Minimum jump penalty is 2 cycles: one JUMP_WAIT cycle with resolve at its end, plus REDIRECT. Each additional resolve cycle adds 1.
- Load-use penalty is 1 cycle.
- Simultaneous jump in ID and load-use hazard: load-use wins and `pipline_stop_jump` stays 0 that cycle.
- Resolve in the same cycle the timeout is reached: the resolve wins and `jump_err` is not set.

## Structure
- Shared `defines.vh` holds the state encodings (2 bits) and `REG_ZERO`=5'd0.
- Sub-module `hazard_detect` is the combinational load-use comparator; it is instantiated once.
- The FSM, `npc_q`, the wait counter and the performance counters live in the top module.

## Test plan
- Reset, then release: BOOT lasts 1 cycle with `flush_ifid`=1, then RUN; all counters read 0.
- `ex_mem_read`=1, `ex_rd`=5, ID `id_rs2`=5 with `id_rs2_used`=1: `pipline_stop`=1 for exactly 1 cycle and `load_stall_cnt`=1. With `ex_rd`=0 there is no stall.
- Jump in ID, resolve after 3 cycles with taken=1, target 0x100: `pipline_stop_jump` high for 3 cycles, REDIRECT shows `npc`=0x100, PC reads 0x100 afterwards, `jump_stall_cnt`=3.
- Not-taken resolve with `ex_br_pc4`=0x24: `npc`=0x24 in REDIRECT.
- Jump in ID with no resolve: after 15 cycles `jump_err`=1, `npc`=`ex_br_pc4`, state returns to RUN.
- jalr with a load-use hazard on rs1, plus a `rst_sc` pulse during JUMP_WAIT: stall precedes JUMP_WAIT; the reset returns the block to BOOT with `npc`=0.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared definitions for the fetch/hazard controller.
//   state_t  - 2-bit FSM state encoding
//   REG_ZERO - architectural zero register index (never a real hazard source)
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_JUMP_WAIT = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/stall_ctrl_hazard_detect.sv
// stall_ctrl_hazard_detect: combinational load-use comparator.
// Ports:
//   id_valid, id_rs1/id_rs2, id_rs1_used/id_rs2_used - ID-stage sources
//   ex_valid, ex_mem_read, ex_rd                      - EX-stage load
//   hazard                                            - ID reads the EX load result
module stall_ctrl_hazard_detect
  import stall_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_rs2_used && (id_rs2 == ex_rd);

  // Loads into x0 are discarded, so they never create a dependency.
  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != REG_ZERO)
                  && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: fetch/hazard controller driving the PC hold/redirect inputs and
// the IF/ID, ID/EX pipeline register controls.
//
// state      | meaning
// -----------+------------------------------------------------------------
// BOOT       | one cycle after reset; matches the PC's forced-zero cycle
// RUN        | normal flow; load-use stalls and jump detection
// JUMP_WAIT  | fetch held until the control instruction in EX resolves
// REDIRECT   | one cycle presenting npc to the PC; wrong-path fetch dropped
//
// Ports:
//   clk_sc, rst_sc (sync, active-high)
//   id_* / ex_*            - pipeline status inputs
//   pipline_stop(_jump)    - PC hold controls, npc drives PC din
//   stall_ifid, flush_ifid, flush_idex - pipeline register controls
//   jump_err               - sticky jump-wait timeout flag
//   load_stall_cnt, jump_stall_cnt - saturating stall-cycle counters
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int JUMP_TIMEOUT = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk_sc,
  input  logic             rst_sc,
  input  logic             id_valid,
  input  logic             id_is_jump,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_resolved,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic [31:0]      ex_br_pc4,
  output logic             pipline_stop,
  output logic             pipline_stop_jump,
  output logic [31:0]      npc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             jump_err,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] jump_stall_cnt
);

  localparam int                WAIT_W    = $clog2(JUMP_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(JUMP_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state;
  logic [31:0]       r_npc_q;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_jump_err;
  logic [CNT_W-1:0]  r_load_cnt;
  logic [CNT_W-1:0]  r_jump_cnt;
  logic              w_hazard;
  logic              w_jump_in_id;

  stall_ctrl_hazard_detect u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (w_hazard)
  );

  // Outputs are combinational; forcing BOOT while reset is asserted makes the
  // reset take effect on the outputs immediately rather than at the next edge.
  assign w_state      = rst_sc ? ST_BOOT : r_state;
  assign w_jump_in_id = id_valid && id_is_jump && !w_hazard;

  always_comb begin
    pipline_stop      = 1'b0;
    pipline_stop_jump = 1'b0;
    stall_ifid        = 1'b0;
    flush_ifid        = 1'b0;
    flush_idex        = 1'b0;
    case (w_state)
      ST_BOOT: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      ST_RUN: begin
        if (w_hazard) begin
          pipline_stop = 1'b1;
          stall_ifid   = 1'b1;
          flush_idex   = 1'b1;
        end else if (w_jump_in_id) begin
          pipline_stop_jump = 1'b1;
        end
      end
      ST_JUMP_WAIT: begin
        pipline_stop_jump = 1'b1;
        stall_ifid        = 1'b1;
        flush_idex        = 1'b1;
      end
      ST_REDIRECT: begin
        flush_ifid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sc) begin
    if (rst_sc) begin
      r_state    <= ST_BOOT;
      r_npc_q    <= '0;
      r_wait_cnt <= '0;
      r_jump_err <= 1'b0;
      r_load_cnt <= '0;
      r_jump_cnt <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_jump_in_id) begin
            r_state    <= ST_JUMP_WAIT;
            r_wait_cnt <= '0;
          end
        end
        ST_JUMP_WAIT: begin
          // A resolve on the final wait cycle still wins over the timeout.
          if (ex_br_resolved) begin
            r_npc_q <= ex_br_taken ? ex_br_target : ex_br_pc4;
            r_state <= ST_REDIRECT;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_jump_err <= 1'b1;
            r_npc_q    <= ex_br_pc4;
            r_state    <= ST_REDIRECT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_REDIRECT: r_state <= ST_RUN;
        default:     r_state <= ST_BOOT;
      endcase

      if (pipline_stop && (r_load_cnt != '1))
        r_load_cnt <= r_load_cnt + 1'b1;
      if (pipline_stop_jump && (r_jump_cnt != '1))
        r_jump_cnt <= r_jump_cnt + 1'b1;
    end
  end

  assign npc            = rst_sc ? 32'd0 : r_npc_q;
  assign jump_err       = r_jump_err;
  assign load_stall_cnt = r_load_cnt;
  assign jump_stall_cnt = r_jump_cnt;

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

  // Narrow counters so saturation is reachable in a short run.
  localparam int CNT_W = 4;

  logic             clk_sc = 1'b0;
  logic             rst_sc;
  logic             id_valid, id_is_jump, id_rs1_used, id_rs2_used;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_valid, ex_mem_read, ex_br_resolved, ex_br_taken;
  logic [31:0]      ex_br_target, ex_br_pc4;
  logic             pipline_stop, pipline_stop_jump;
  logic [31:0]      npc;
  logic             stall_ifid, flush_ifid, flush_idex, jump_err;
  logic [CNT_W-1:0] load_stall_cnt, jump_stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  stall_ctrl #(.JUMP_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk_sc            (clk_sc),
    .rst_sc            (rst_sc),
    .id_valid          (id_valid),
    .id_is_jump        (id_is_jump),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rs1_used       (id_rs1_used),
    .id_rs2_used       (id_rs2_used),
    .ex_valid          (ex_valid),
    .ex_mem_read       (ex_mem_read),
    .ex_rd             (ex_rd),
    .ex_br_resolved    (ex_br_resolved),
    .ex_br_taken       (ex_br_taken),
    .ex_br_target      (ex_br_target),
    .ex_br_pc4         (ex_br_pc4),
    .pipline_stop      (pipline_stop),
    .pipline_stop_jump (pipline_stop_jump),
    .npc               (npc),
    .stall_ifid        (stall_ifid),
    .flush_ifid        (flush_ifid),
    .flush_idex        (flush_idex),
    .jump_err          (jump_err),
    .load_stall_cnt    (load_stall_cnt),
    .jump_stall_cnt    (jump_stall_cnt)
  );

  always #5 clk_sc = ~clk_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sc);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_is_jump = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
    ex_br_resolved = 0; ex_br_taken = 0;
    ex_br_target = 0; ex_br_pc4 = 0;
  endtask

  initial begin
    rst_sc = 1;
    clear_inputs();
    #1;
    // Outputs must show BOOT values as soon as reset is high.
    chk("rst_flush_ifid", 32'(flush_ifid), 1);
    chk("rst_flush_idex", 32'(flush_idex), 1);
    chk("rst_npc", npc, 0);
    tick(); tick();
    chk("rst_stop", 32'(pipline_stop), 0);
    chk("rst_stop_jump", 32'(pipline_stop_jump), 0);
    chk("rst_load_cnt", 32'(load_stall_cnt), 0);
    chk("rst_jump_cnt", 32'(jump_stall_cnt), 0);
    chk("rst_jump_err", 32'(jump_err), 0);

    // BOOT cycle after release, then RUN.
    rst_sc = 0; #1;
    chk("boot_flush_ifid", 32'(flush_ifid), 1);
    chk("boot_flush_idex", 32'(flush_idex), 1);
    tick();
    chk("run_flush_ifid", 32'(flush_ifid), 0);
    chk("run_flush_idex", 32'(flush_idex), 0);

    // Load-use on rs2.
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5;
    id_valid = 1; id_rs2 = 5; id_rs2_used = 1; #1;
    chk("lu_stop", 32'(pipline_stop), 1);
    chk("lu_stall_ifid", 32'(stall_ifid), 1);
    chk("lu_flush_idex", 32'(flush_idex), 1);
    tick();
    ex_mem_read = 0; ex_rd = 9; #1;
    chk("lu_stop_clear", 32'(pipline_stop), 0);
    chk("lu_load_cnt", 32'(load_stall_cnt), 1);

    // Load into x0 is never a hazard.
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; #1;
    chk("lu_x0_stop", 32'(pipline_stop), 0);
    // Matching rs1 that is not used is not a hazard.
    ex_rd = 7; id_rs1 = 7; id_rs1_used = 0; id_rs2 = 8; #1;
    chk("lu_unused_stop", 32'(pipline_stop), 0);
    // Load in EX marked invalid is not a hazard.
    id_rs1_used = 1; ex_valid = 0; #1;
    chk("lu_exinv_stop", 32'(pipline_stop), 0);
    tick();
    chk("lu_load_cnt2", 32'(load_stall_cnt), 1);
    clear_inputs();

    // Jump bit without a valid ID instruction is ignored.
    id_is_jump = 1; #1;
    chk("jmp_invalid", 32'(pipline_stop_jump), 0);

    // Taken jump, resolve on the second JUMP_WAIT cycle.
    id_valid = 1; #1;
    chk("jt_stop_jump_run", 32'(pipline_stop_jump), 1);
    chk("jt_stall_run", 32'(stall_ifid), 0);
    tick();
    clear_inputs(); #1;
    chk("jt_stop_jump_w1", 32'(pipline_stop_jump), 1);
    chk("jt_stall_w1", 32'(stall_ifid), 1);
    chk("jt_flush_idex_w1", 32'(flush_idex), 1);
    tick();
    ex_br_resolved = 1; ex_br_taken = 1; ex_br_target = 32'h100; ex_br_pc4 = 32'h24; #1;
    chk("jt_stop_jump_w2", 32'(pipline_stop_jump), 1);
    tick();
    clear_inputs(); #1;
    chk("jt_redir_stop_jump", 32'(pipline_stop_jump), 0);
    chk("jt_redir_npc", npc, 32'h100);
    chk("jt_redir_flush_ifid", 32'(flush_ifid), 1);
    chk("jt_jump_cnt", 32'(jump_stall_cnt), 3);
    tick();
    chk("jt_run_flush_ifid", 32'(flush_ifid), 0);
    chk("jt_run_npc", npc, 32'h100);

    // Resolve outside JUMP_WAIT is ignored.
    ex_br_resolved = 1; ex_br_taken = 1; ex_br_target = 32'h200; #1;
    tick();
    clear_inputs(); #1;
    chk("stray_npc", npc, 32'h100);
    chk("stray_flush_ifid", 32'(flush_ifid), 0);

    // Not-taken, minimum penalty: resolve on the first JUMP_WAIT cycle.
    id_valid = 1; id_is_jump = 1; #1;
    tick();
    clear_inputs();
    ex_br_resolved = 1; ex_br_taken = 0; ex_br_target = 32'h300; ex_br_pc4 = 32'h24; #1;
    tick();
    clear_inputs(); #1;
    chk("nt_redir_npc", npc, 32'h24);
    chk("nt_redir_flush_ifid", 32'(flush_ifid), 1);
    chk("nt_jump_cnt", 32'(jump_stall_cnt), 5);
    tick();

    // Resolve on the 15th wait cycle beats the timeout.
    id_valid = 1; id_is_jump = 1; #1;
    tick();
    clear_inputs(); ex_br_pc4 = 32'h60;
    for (int i = 0; i < 14; i++) begin
      #1;
      chk("rt_stop_jump", 32'(pipline_stop_jump), 1);
      tick();
    end
    ex_br_resolved = 1; ex_br_taken = 1; ex_br_target = 32'h1f0; #1;
    chk("rt_stop_jump_last", 32'(pipline_stop_jump), 1);
    tick();
    clear_inputs(); #1;
    chk("rt_redir_npc", npc, 32'h1f0);
    chk("rt_jump_err", 32'(jump_err), 0);
    chk("rt_jump_cnt_sat", 32'(jump_stall_cnt), 15);
    tick();

    // No resolve: timeout after 15 JUMP_WAIT cycles.
    id_valid = 1; id_is_jump = 1; #1;
    tick();
    clear_inputs(); ex_br_pc4 = 32'h48;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("to_wait_stop_jump", 32'(pipline_stop_jump), 1);
      chk("to_wait_err", 32'(jump_err), 0);
      tick();
    end
    #1;
    chk("to_redir_stop_jump", 32'(pipline_stop_jump), 0);
    chk("to_redir_flush_ifid", 32'(flush_ifid), 1);
    chk("to_jump_err", 32'(jump_err), 1);
    chk("to_npc", npc, 32'h48);
    chk("to_jump_cnt_nowrap", 32'(jump_stall_cnt), 15);
    tick();
    chk("to_run_flush_ifid", 32'(flush_ifid), 0);
    chk("to_err_sticky", 32'(jump_err), 1);

    // jalr depending on a load: stall first, then JUMP_WAIT, then reset.
    id_valid = 1; id_is_jump = 1; id_rs1 = 3; id_rs1_used = 1;
    ex_valid = 1; ex_mem_read = 1; ex_rd = 3; #1;
    chk("jl_stop", 32'(pipline_stop), 1);
    chk("jl_stop_jump", 32'(pipline_stop_jump), 0);
    tick();
    chk("jl_load_cnt", 32'(load_stall_cnt), 2);
    ex_mem_read = 0; #1;
    chk("jl_stop_after", 32'(pipline_stop), 0);
    chk("jl_stop_jump_after", 32'(pipline_stop_jump), 1);
    tick();
    clear_inputs(); #1;
    chk("jl_wait_stall", 32'(stall_ifid), 1);
    chk("jl_wait_stop_jump", 32'(pipline_stop_jump), 1);
    rst_sc = 1; ex_br_resolved = 1; ex_br_taken = 1; ex_br_target = 32'h500; #1;
    chk("jl_rst_stop_jump", 32'(pipline_stop_jump), 0);
    chk("jl_rst_flush_ifid", 32'(flush_ifid), 1);
    chk("jl_rst_npc", npc, 0);
    tick();
    rst_sc = 0; clear_inputs(); #1;
    chk("jl_boot_flush_ifid", 32'(flush_ifid), 1);
    chk("jl_boot_npc", npc, 0);
    chk("jl_boot_err", 32'(jump_err), 0);
    chk("jl_boot_load_cnt", 32'(load_stall_cnt), 0);
    chk("jl_boot_jump_cnt", 32'(jump_stall_cnt), 0);
    tick();
    chk("jl_run_flush_ifid", 32'(flush_ifid), 0);
    chk("jl_run_npc", npc, 0);
    chk("jl_run_stop_jump", 32'(pipline_stop_jump), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
